// File: rtl/muldiv_pkg.sv
// Shared definitions for the muldiv scheduler slice.
//   - RV32M funct3 encodings for the multiply/divide operations
//   - scheduler FSM state type
//   - default operand/result width and tag width
package muldiv_pkg;

  localparam int unsigned OP_LN_DEFAULT = 32;
  localparam int unsigned TAG_W_DEFAULT = 4;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_rr_arb.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   valid    : request valid per requester (bit N = requester N)
//   accept   : the granted request was taken this cycle
//   grant    : one-hot grant (all zero when nothing is valid)
// A lone valid requester always wins; on contention the pointer decides.
// After every acceptance the pointer favours the requester that was not taken.
module muldiv_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // Taking requester 0 hands priority to 1 and vice versa.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// Scheduler sharing one multi-cycle muldiv unit between two requesters.
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/ready         : request handshake, requester N (N = 0, 1)
//   reqN_op1/op2/funct3/tag  : request payload
//   respN_valid/ready        : response handshake, requester N
//   respN_result/tag         : response payload (don't-care while not valid)
//   flush                    : kill the in-flight operation, no response
//   md_op1/op2/funct3        : operands/operation to the muldiv unit
//   md_start, md_ack         : single-cycle start and result-acknowledge pulses
//   md_result, md_done       : result from the unit, done held until md_ack
// One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int unsigned OP_LN = OP_LN_DEFAULT,
  parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_LN-1:0] req0_op1,
  input  logic [OP_LN-1:0] req0_op2,
  input  logic [2:0]       req0_funct3,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_LN-1:0] req1_op1,
  input  logic [OP_LN-1:0] req1_op2,
  input  logic [2:0]       req1_funct3,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [OP_LN-1:0] resp0_result,
  output logic [TAG_W-1:0] resp0_tag,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [OP_LN-1:0] resp1_result,
  output logic [TAG_W-1:0] resp1_tag,
  input  logic             flush,
  output logic [OP_LN-1:0] md_op1,
  output logic [OP_LN-1:0] md_op2,
  output logic [2:0]       md_funct3,
  output logic             md_start,
  output logic             md_ack,
  input  logic [OP_LN-1:0] md_result,
  input  logic             md_done
);

  state_t state, state_next;
  logic   kill;

  logic [1:0] valid;
  logic [1:0] grant;
  logic       accept;
  logic       resp_fire;

  logic [OP_LN-1:0] op1_q;
  logic [OP_LN-1:0] op2_q;
  logic [OP_LN-1:0] res_q;
  logic [2:0]       f3_q;
  logic [TAG_W-1:0] tag_q;
  logic             id_q;

  assign valid = {req1_valid, req0_valid};

  muldiv_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .accept (accept),
    .grant  (grant)
  );

  assign accept    = !rst && (state == IDLE) && !flush && |(valid & grant);
  assign resp_fire = id_q ? resp1_ready : resp0_ready;

  // State register and kill flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kill  <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == IDLE) begin
        kill <= 1'b0;
      end else if (flush && (state == ISSUE || state == WAIT)) begin
        kill <= 1'b1;
      end
    end
  end

  // Next-state logic. A flush on the md_done cycle itself counts as a kill.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT:  if (md_done) state_next = (kill || flush) ? IDLE : RESP;
      RESP:  if (flush || resp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; every handshake/pulse output is forced low while rst is high.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    md_start    = 1'b0;
    md_ack      = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          req0_ready = !flush && grant[0];
          req1_ready = !flush && grant[1];
        end
        ISSUE: md_start = 1'b1;
        WAIT:  md_ack   = md_done;
        RESP: begin
          resp0_valid = !flush && !id_q;
          resp1_valid = !flush &&  id_q;
        end
        default: ;
      endcase
    end
  end

  // Payload registers: no reset needed, only read under a valid state.
  always_ff @(posedge clk) begin
    if (accept) begin
      op1_q <= grant[1] ? req1_op1    : req0_op1;
      op2_q <= grant[1] ? req1_op2    : req0_op2;
      f3_q  <= grant[1] ? req1_funct3 : req0_funct3;
      tag_q <= grant[1] ? req1_tag    : req0_tag;
      id_q  <= grant[1];
    end
    if (state == WAIT && md_done) begin
      res_q <= md_result;
    end
  end

  assign md_op1       = op1_q;
  assign md_op2       = op2_q;
  assign md_funct3    = f3_q;
  assign resp0_result = res_q;
  assign resp0_tag    = tag_q;
  assign resp1_result = res_q;
  assign resp1_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with a behavioural muldiv unit model.
module tb_muldiv_sched;
  import muldiv_pkg::*;

  localparam int W  = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req0_valid = 0, req1_valid = 0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
  logic [2:0]    req0_funct3 = 0, req1_funct3 = 0;
  logic [TW-1:0] req0_tag = 0, req1_tag = 0;
  logic          resp0_valid, resp1_valid;
  logic          resp0_ready = 1, resp1_ready = 1;
  logic [W-1:0]  resp0_result, resp1_result;
  logic [TW-1:0] resp0_tag, resp1_tag;
  logic          flush = 0;
  logic [W-1:0]  md_op1, md_op2, md_result;
  logic [2:0]    md_funct3;
  logic          md_start, md_ack;
  logic          md_done_m = 0;
  logic          spur = 0;
  logic          md_done;

  assign md_done = md_done_m | spur;

  int total = 0;
  int bad   = 0;

  muldiv_sched #(.OP_LN(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_funct3(req0_funct3), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_funct3(req1_funct3), .req1_tag(req1_tag),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_tag(resp0_tag),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_tag(resp1_tag),
    .flush(flush), .md_op1(md_op1), .md_op2(md_op2), .md_funct3(md_funct3),
    .md_start(md_start), .md_ack(md_ack), .md_result(md_result), .md_done(md_done)
  );

  // Behavioural muldiv unit: result computed at md_start, md_done raised
  // md_lat cycles later and held until md_ack.
  int           md_lat = 1;
  int           cnt = 0;
  bit           pend = 0, busy = 0;
  int           starts = 0, acks = 0, op_changes = 0;
  logic [W-1:0] cap1 = 0, cap2 = 0;

  function automatic logic [W-1:0] calc(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    case (f)
      MUL:     return a * b;
      DIV:     return $signed(a) / $signed(b);
      DIVU:    return a / b;
      REM:     return $signed(a) % $signed(b);
      REMU:    return a % b;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      pend <= 0; busy <= 0; md_done_m <= 0; cnt <= 0;
    end else begin
      if (md_start) begin
        starts <= starts + 1;
        pend <= 1; busy <= 1; cnt <= md_lat;
        cap1 <= md_op1; cap2 <= md_op2;
        md_result <= calc(md_funct3, md_op1, md_op2);
      end else if (pend) begin
        if (cnt <= 1) begin md_done_m <= 1; pend <= 0; end
        else cnt <= cnt - 1;
      end
      if (md_ack) begin
        acks <= acks + 1; md_done_m <= 0; busy <= 0;
      end
      if (busy && !md_start && (md_op1 !== cap1 || md_op2 !== cap2))
        op_changes <= op_changes + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0; flush = 0;
    resp0_ready = 1; resp1_ready = 1;
    cyc(2);
    rst = 0;
    #1;
  endtask

  task automatic drive_req(input int n, input logic [2:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TW-1:0] t);
    if (n == 0) begin
      req0_funct3 = f; req0_op1 = a; req0_op2 = b; req0_tag = t; req0_valid = 1;
    end else begin
      req1_funct3 = f; req1_op1 = a; req1_op2 = b; req1_tag = t; req1_valid = 1;
    end
  endtask

  // Waits for reqN_ready, lets the handshake edge pass, then drops valid.
  task automatic wait_accept(input int n, output bit ok);
    ok = 0;
    #1;
    for (int i = 0; i < 60; i++) begin
      if ((n == 0) ? req0_ready : req1_ready) begin ok = 1; break; end
      cyc();
    end
    if (ok) begin
      cyc();
      if (n == 0) req0_valid = 0; else req1_valid = 0;
    end
  endtask

  task automatic wait_resp(input int n, output bit ok, output int cycles);
    ok = 0; cycles = 0;
    for (int i = 0; i < 60; i++) begin
      if ((n == 0) ? resp0_valid : resp1_valid) begin ok = 1; break; end
      cyc(); cycles++;
    end
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    rst = 1;
    drive_req(0, MUL, 1, 1, 1);
    drive_req(1, MUL, 2, 2, 2);
    cyc(2);
    outs = {req0_ready, req1_ready, resp0_valid, resp1_valid, md_start, md_ack};
    total++;
    if (outs !== 6'b0) begin bad++; $display("FAIL reset_outputs: got %b want 000000", outs); end
    req0_valid = 0; req1_valid = 0; rst = 0;
    cyc();
    spur = 1; #1;
    total++;
    if (md_ack !== 1'b0) begin bad++; $display("FAIL spurious_done_ack: got %b want 0", md_ack); end
    cyc(); spur = 0;
    req1_valid = 1; #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++; $display("FAIL lone_req1_grant: got %b want 01", {req0_ready, req1_ready});
    end
    req1_valid = 0; #1;
  endtask

  task automatic test_mul();
    bit ok; int c, r1, s0, a0;
    md_lat = 4; s0 = starts; a0 = acks; r1 = 0; c = 0;
    drive_req(0, MUL, 7, 6, 3);
    wait_accept(0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL mul_accept: got timeout want accept"); end
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp0_valid) begin ok = 1; break; end
      if (resp1_valid) r1++;
      cyc(); c++;
    end
    total++;
    if (!ok || c != 6) begin bad++; $display("FAIL mul_latency: got ok=%0d cycles=%0d want cycles=6", ok, c); end
    total++;
    if (resp0_result !== 32'd42 || resp0_tag !== 4'd3) begin
      bad++; $display("FAIL mul_result: got %0d tag %0d want 42 tag 3", resp0_result, resp0_tag);
    end
    total++;
    if (r1 != 0 || resp1_valid !== 1'b0) begin bad++; $display("FAIL mul_resp1_quiet: got %0d want 0", r1); end
    cyc();
    total++;
    if (resp0_valid !== 1'b0) begin bad++; $display("FAIL mul_resp_drop: got %b want 0", resp0_valid); end
    total++;
    if (starts - s0 != 1 || acks - a0 != 1) begin
      bad++; $display("FAIL mul_pulses: got starts=%0d acks=%0d want 1/1", starts - s0, acks - a0);
    end
  endtask

  task automatic test_arb();
    bit ok; int c, seen1;
    do_reset();
    md_lat = 2; seen1 = 0;
    drive_req(0, DIV, 100, 7, 1);
    drive_req(1, REMU, 100, 7, 2);
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL arb_first: got %b want 10", {req0_ready, req1_ready});
    end
    cyc(); req0_valid = 0; #1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp0_valid) begin ok = 1; break; end
      if (req1_ready) seen1++;
      cyc();
    end
    total++;
    if (!ok || resp0_result !== 32'd14 || resp0_tag !== 4'd1 || seen1 != 0) begin
      bad++; $display("FAIL arb_resp0: got ok=%0d res=%0d tag=%0d r1rdy=%0d want 14 tag 1", ok, resp0_result, resp0_tag, seen1);
    end
    cyc();
    wait_accept(1, ok);
    wait_resp(1, ok, c);
    total++;
    if (!ok || resp1_result !== 32'd2 || resp1_tag !== 4'd2) begin
      bad++; $display("FAIL arb_resp1: got ok=%0d res=%0d tag=%0d want 2 tag 2", ok, resp1_result, resp1_tag);
    end
    cyc();
    req0_valid = 1; req1_valid = 1; #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL arb_ptr_back: got %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0; #1;
  endtask

  task automatic test_backpressure();
    bit ok; int c;
    md_lat = 1; resp0_ready = 0;
    drive_req(0, MUL, 9, 9, 5);
    wait_accept(0, ok);
    drive_req(1, MUL, 11, 11, 7);
    wait_resp(0, ok, c);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({resp0_valid, resp0_result, resp0_tag, req1_ready, resp1_valid} !== {1'b1, 32'd81, 4'd5, 1'b0, 1'b0}) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b res=%0d tag=%0d r1rdy=%b want 1 81 5 0", i, resp0_valid, resp0_result, resp0_tag, req1_ready);
      end
      cyc();
    end
    resp0_ready = 1;
    cyc();
    total++;
    if (req1_ready !== 1'b1 || resp0_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release: got r1rdy=%b v0=%b want 1 0", req1_ready, resp0_valid);
    end
    cyc(); req1_valid = 0;
    wait_resp(1, ok, c);
    total++;
    if (!ok || resp1_result !== 32'd121 || resp1_tag !== 4'd7) begin
      bad++; $display("FAIL bp_resp1: got ok=%0d res=%0d tag=%0d want 121 tag 7", ok, resp1_result, resp1_tag);
    end
    cyc();
  endtask

  task automatic test_flush();
    bit ok, acked; int rv, s0, a0, c;
    md_lat = 3; s0 = starts; a0 = acks; rv = 0; acked = 0;
    drive_req(0, MUL, 5, 5, 4);
    wait_accept(0, ok);
    flush = 1;
    cyc();
    flush = 0;
    for (int i = 0; i < 30; i++) begin
      if (resp0_valid || resp1_valid) rv++;
      if (md_ack) begin acked = 1; break; end
      cyc();
    end
    cyc();
    total++;
    if (!acked || rv != 0 || starts - s0 != 1 || acks - a0 != 1) begin
      bad++; $display("FAIL flush_kill: got acked=%0d resp=%0d starts=%0d acks=%0d want 1 0 1 1", acked, rv, starts - s0, acks - a0);
    end
    drive_req(0, MUL, 1, 1, 0); #1;
    total++;
    if ({req0_ready, md_ack, resp0_valid} !== 3'b100) begin
      bad++; $display("FAIL flush_idle: got %b want 100", {req0_ready, md_ack, resp0_valid});
    end
    req0_valid = 0; #1;
    // Flush while the response is being presented.
    resp0_ready = 0;
    drive_req(0, MUL, 2, 2, 1);
    wait_accept(0, ok);
    wait_resp(0, ok, c);
    flush = 1; #1;
    total++;
    if (!ok || resp0_valid !== 1'b0) begin
      bad++; $display("FAIL flush_resp_drop: got ok=%0d v0=%b want 1 0", ok, resp0_valid);
    end
    cyc();
    flush = 0;
    req0_valid = 1; #1;
    total++;
    if ({req0_ready, resp0_valid} !== 2'b10) begin
      bad++; $display("FAIL flush_resp_idle: got %b want 10", {req0_ready, resp0_valid});
    end
    req0_valid = 0; resp0_ready = 1; #1;
  endtask

  task automatic test_rst_mid();
    bit ok; int rv, c;
    md_lat = 8; rv = 0;
    drive_req(0, MUL, 20, 20, 9);
    wait_accept(0, ok);
    cyc();
    rst = 1; req0_valid = 1;
    cyc();
    total++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, md_start, md_ack} !== 6'b0) begin
      bad++; $display("FAIL rst_mid_outputs: got %b want 000000", {req0_ready, req1_ready, resp0_valid, resp1_valid, md_start, md_ack});
    end
    req0_valid = 0; rst = 0;
    for (int i = 0; i < 15; i++) begin
      if (resp0_valid || resp1_valid) rv++;
      cyc();
    end
    total++;
    if (rv != 0) begin bad++; $display("FAIL rst_mid_no_resp: got %0d want 0", rv); end
    md_lat = 2;
    drive_req(0, MUL, 3, 5, 2);
    wait_accept(0, ok);
    wait_resp(0, ok, c);
    total++;
    if (!ok || resp0_result !== 32'd15 || resp0_tag !== 4'd2) begin
      bad++; $display("FAIL rst_mid_new_op: got ok=%0d res=%0d tag=%0d want 15 tag 2", ok, resp0_result, resp0_tag);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp0 [5];
    logic [W-1:0] exp1 [5];
    int n0, n1, m0, m1, g;
    bit acc0, acc1;
    exp0 = '{32'd3, 32'd6, 32'd9, 32'd12, 32'd15};
    exp1 = '{32'd100, 32'd50, 32'd33, 32'd25, 32'd20};
    do_reset();
    md_lat = 1; n0 = 0; n1 = 0; m0 = 0; m1 = 0; g = 0;
    drive_req(0, MUL, 1, 3, 0);
    drive_req(1, DIVU, 100, 1, 8);
    #1;
    for (int cyc_n = 0; cyc_n < 300 && (m0 < 5 || m1 < 5); cyc_n++) begin
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0 || acc1) begin
        total++;
        if (acc1 !== (g % 2 == 1)) begin
          bad++; $display("FAIL b2b_grant%0d: got req%0d want req%0d", g, acc1 ? 1 : 0, g % 2);
        end
        g++;
      end
      if (acc0) n0++;
      if (acc1) n1++;
      if (resp0_valid && m0 < 5) begin
        total++;
        if (resp0_result !== exp0[m0] || resp0_tag !== 4'(m0)) begin
          bad++; $display("FAIL b2b_resp0_%0d: got %0d tag %0d want %0d tag %0d", m0, resp0_result, resp0_tag, exp0[m0], m0);
        end
        m0++;
      end
      if (resp1_valid && m1 < 5) begin
        total++;
        if (resp1_result !== exp1[m1] || resp1_tag !== 4'(8 + m1)) begin
          bad++; $display("FAIL b2b_resp1_%0d: got %0d tag %0d want %0d tag %0d", m1, resp1_result, resp1_tag, exp1[m1], 8 + m1);
        end
        m1++;
      end
      cyc();
      if (acc0) begin
        if (n0 < 5) drive_req(0, MUL, 32'(n0 + 1), 3, 4'(n0)); else req0_valid = 0;
      end
      if (acc1) begin
        if (n1 < 5) drive_req(1, DIVU, 100, 32'(n1 + 1), 4'(8 + n1)); else req1_valid = 0;
      end
      #1;
    end
    total++;
    if (g != 10 || m0 != 5 || m1 != 5) begin
      bad++; $display("FAIL b2b_count: got grants=%0d r0=%0d r1=%0d want 10 5 5", g, m0, m1);
    end
  endtask

  task automatic test_operand_stability();
    total++;
    if (op_changes != 0) begin
      bad++; $display("FAIL md_operand_stable: got %0d changes want 0", op_changes);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_arb();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    test_operand_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
